// File: rtl/seg_scan_driver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Display stage behind the 8051 segment latch. Four 8-bit segment patterns
// arrive from another clock domain and are time-multiplexed onto one shared
// segment bus with four one-hot digit enables. This drives a multiplexed
// 7-segment display.
//
// A frame is four digit slots of DIV cycles each. Every slot begins with BLANK
// dead cycles so the previous digit's pattern never ghosts onto the next digit.
// The patterns are snapshotted only at frame start, so a frame never tears.
//
// Parameters
//   DIV        clock cycles per digit slot (>= 2)
//   BLANK      dead cycles at the start of each slot (0 <= BLANK < DIV)
//   ACTIVE_LOW 1 inverts seg_bus and dig_en at the pins
//
// Ports
//   Clk        system clock, rising edge
//   Reset      asynchronous, active-high reset
//   Enable     scan enable; low keeps the display dark
//   seg0_in..seg3_in  digit patterns (bit7 = dp), asynchronous to Clk
//   seg_bus    shared segment drive (registered)
//   dig_en     one-hot digit enable, bit n = digit n (registered)
//   frame_tick one-cycle pulse in the first cycle of each frame (registered)
// -----------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int DIV        = 50000,
  parameter int BLANK      = 500,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [7:0] seg0_in,
  input  logic [7:0] seg1_in,
  input  logic [7:0] seg2_in,
  input  logic [7:0] seg3_in,
  output logic [7:0] seg_bus,
  output logic [3:0] dig_en,
  output logic       frame_tick
);

  // Slot counter width; DIV = 2 still needs one bit.
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [PW-1:0] BLANK_P = PW'(BLANK);

  // Inactive pin levels for the chosen polarity.
  localparam logic [7:0] SEG_OFF = {8{ACTIVE_LOW}};
  localparam logic [3:0] DIG_OFF = {4{ACTIVE_LOW}};

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (DIV < 2) begin : g_bad_div
    $error("seg_scan_driver: DIV must be >= 2 (DIV=%0d)", DIV);
  end

  if ((BLANK < 0) || (BLANK >= DIV)) begin : g_bad_blank
    $error("seg_scan_driver: BLANK must satisfy 0 <= BLANK < DIV (BLANK=%0d, DIV=%0d)",
           BLANK, DIV);
  end

  // ---------------------------------------------------------------------------
  // Input synchronizers: two flops per bit, all 32 bits in parallel.
  // Bits are synchronized individually, so a multi-bit change may settle over
  // two cycles; the frame-start snapshot hides that from the pins.
  // ---------------------------------------------------------------------------
  logic [3:0][7:0] seg_async;
  logic [3:0][7:0] sync1_q;
  logic [3:0][7:0] sync2_q;

  assign seg_async = {seg3_in, seg2_in, seg1_in, seg0_in};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= seg_async;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan state
  //   run_q  : scanning active
  //   idx_q  : digit currently owning the slot
  //   pre_q  : cycle position inside the slot, 0..DIV-1
  //   snap_q : patterns frozen for the current frame
  // ---------------------------------------------------------------------------
  logic            run_q, run_d;
  logic [1:0]      idx_q, idx_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [3:0][7:0] snap_q, snap_d;
  logic            tick_q, tick_d;

  always_comb begin
    run_d  = run_q;
    idx_d  = idx_q;
    pre_d  = pre_q;
    snap_d = snap_q;
    tick_d = 1'b0;

    if (!run_q) begin
      // Idle: hold the counters at the frame origin.
      pre_d = '0;
      idx_d = '0;
      if (Enable) begin
        run_d  = 1'b1;
        snap_d = sync2_q;
        tick_d = 1'b1;
      end
    end else if (!Enable) begin
      // Enable has priority over a slot or frame wrap on the same edge.
      run_d = 1'b0;
      pre_d = '0;
      idx_d = '0;
    end else if (pre_q < PRE_MAX) begin
      pre_d = pre_q + 1'b1;
    end else begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        snap_d = sync2_q;
        tick_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_q  <= 1'b0;
      idx_q  <= '0;
      pre_q  <= '0;
      snap_q <= '0;
      tick_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      idx_q  <= idx_d;
      pre_q  <= pre_d;
      snap_q <= snap_d;
      tick_q <= tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // The output registers are loaded from the next-state values, so in any
  // cycle the pins describe the (run, idx, pre, snap) held in that same cycle.
  // With BLANK = 0 there is no blank phase and the compare is skipped.
  // ---------------------------------------------------------------------------
  logic in_blank;

  if (BLANK > 0) begin : g_blank
    assign in_blank = (pre_d < BLANK_P);
  end else begin : g_no_blank
    assign in_blank = 1'b0;
  end

  logic [7:0] seg_drive;
  logic [3:0] dig_drive;
  logic [7:0] seg_bus_d, seg_bus_q;
  logic [3:0] dig_en_d, dig_en_q;

  always_comb begin
    seg_drive = 8'h00;
    dig_drive = 4'b0000;
    if (run_d && !in_blank) begin
      // A single shifted bit keeps dig_en one-hot by construction.
      dig_drive = 4'b0001 << idx_d;
      seg_drive = snap_d[idx_d];
    end
    seg_bus_d = seg_drive ^ SEG_OFF;
    dig_en_d  = dig_drive ^ DIG_OFF;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      seg_bus_q <= SEG_OFF;
      dig_en_q  <= DIG_OFF;
    end else begin
      seg_bus_q <= seg_bus_d;
      dig_en_q  <= dig_en_d;
    end
  end

  assign seg_bus    = seg_bus_q;
  assign dig_en     = dig_en_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
`timescale 1ns/1ps
// Testbench for seg_scan_driver. Three instances with different parameter sets
// share the stimulus; a time-based reference model predicts every output.
module tb_seg_scan_driver;

  logic Clk = 1'b0;
  logic Reset;
  logic Enable;
  logic [3:0][7:0] sin;

  logic [7:0] seg_a, seg_b, seg_c;
  logic [3:0] dig_a, dig_b, dig_c;
  logic       tick_a, tick_b, tick_c;

  logic [2:0][7:0] o_seg;
  logic [2:0][3:0] o_dig;
  logic [2:0]      o_tick;

  always #5 Clk = ~Clk;

  seg_scan_driver #(.DIV(8), .BLANK(2), .ACTIVE_LOW(1'b0)) dut_a (
    .Clk(Clk), .Reset(Reset), .Enable(Enable),
    .seg0_in(sin[0]), .seg1_in(sin[1]), .seg2_in(sin[2]), .seg3_in(sin[3]),
    .seg_bus(seg_a), .dig_en(dig_a), .frame_tick(tick_a)
  );

  seg_scan_driver #(.DIV(8), .BLANK(2), .ACTIVE_LOW(1'b1)) dut_b (
    .Clk(Clk), .Reset(Reset), .Enable(Enable),
    .seg0_in(sin[0]), .seg1_in(sin[1]), .seg2_in(sin[2]), .seg3_in(sin[3]),
    .seg_bus(seg_b), .dig_en(dig_b), .frame_tick(tick_b)
  );

  seg_scan_driver #(.DIV(2), .BLANK(0), .ACTIVE_LOW(1'b0)) dut_c (
    .Clk(Clk), .Reset(Reset), .Enable(Enable),
    .seg0_in(sin[0]), .seg1_in(sin[1]), .seg2_in(sin[2]), .seg3_in(sin[3]),
    .seg_bus(seg_c), .dig_en(dig_c), .frame_tick(tick_c)
  );

  always_comb begin
    o_seg  = {seg_c, seg_b, seg_a};
    o_dig  = {dig_c, dig_b, dig_a};
    o_tick = {tick_c, tick_b, tick_a};
  end

  // Instance parameters as seen by the model.
  int p_div   [3];
  int p_blank [3];
  bit p_al    [3];

  // Model: m_t counts cycles since the start of the current frame.
  bit              m_run  [3];
  int              m_t    [3];
  bit              m_tick [3];
  logic [3:0][7:0] m_snap [3];
  // Inputs as they were at the previous edge and the one before it.
  logic [3:0][7:0] h1, h2;

  int n_checks;
  int n_pass;
  int cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_run[d]  = 1'b0;
      m_t[d]    = 0;
      m_tick[d] = 1'b0;
      m_snap[d] = '0;
    end
    h1 = '0;
    h2 = '0;
  endtask

  // Advance the model by one rising edge using the inputs present before it.
  // A pattern reaches the snapshot when it was present two edges earlier.
  task automatic model_edge();
    if (Reset) begin
      model_reset();
    end else begin
      for (int d = 0; d < 3; d++) begin
        m_tick[d] = 1'b0;
        if (!m_run[d]) begin
          if (Enable) begin
            m_run[d]  = 1'b1;
            m_t[d]    = 0;
            m_snap[d] = h2;
            m_tick[d] = 1'b1;
          end
        end else if (!Enable) begin
          m_run[d] = 1'b0;
          m_t[d]   = 0;
        end else begin
          m_t[d] = (m_t[d] + 1) % (4 * p_div[d]);
          if (m_t[d] == 0) begin
            m_snap[d] = h2;
            m_tick[d] = 1'b1;
          end
        end
      end
      h2 = h1;
      h1 = sin;
    end
  endtask

  task automatic compare_all(input string where);
    for (int d = 0; d < 3; d++) begin
      logic [7:0] es;
      logic [3:0] ed;
      logic [3:0] dig_true;
      int ph;
      int sl;
      es = 8'h00;
      ed = 4'h0;
      if (m_run[d]) begin
        ph = m_t[d] % p_div[d];
        sl = m_t[d] / p_div[d];
        if (ph >= p_blank[d]) begin
          ed = 4'b0001 << sl;
          es = m_snap[d][sl];
        end
      end
      if (p_al[d]) begin
        es = ~es;
        ed = ~ed;
      end
      dig_true = p_al[d] ? ~o_dig[d] : o_dig[d];
      check($sformatf("%s.c%0d.i%0d.seg", where, cyc, d), 32'(o_seg[d]), 32'(es));
      check($sformatf("%s.c%0d.i%0d.dig", where, cyc, d), 32'(o_dig[d]), 32'(ed));
      check($sformatf("%s.c%0d.i%0d.tick", where, cyc, d), 32'(o_tick[d]), 32'(m_tick[d]));
      check($sformatf("%s.c%0d.i%0d.onehot", where, cyc, d),
            32'($countones(dig_true) <= 1), 32'd1);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge Clk);
    #1;
    cyc++;
    compare_all("step");
  endtask

  // Step until instance d reaches frame position target, bounded.
  task automatic wait_t(input int d, input int target, input string tag);
    int i = 0;
    while (!(m_run[d] && m_t[d] == target) && i < 200) begin
      step();
      i++;
    end
    check({tag, ".reach"}, 32'(m_run[d] && (m_t[d] == target)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    p_div   = '{8, 8, 2};
    p_blank = '{2, 2, 0};
    p_al    = '{1'b0, 1'b1, 1'b0};
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    Enable   = 1'b0;
    sin      = '0;
    Reset    = 1'b0;
    model_reset();

    // Reset state, before any clock edge.
    #1 Reset = 1'b1;
    #1;
    compare_all("rst0");
    check("rst.a.seg",  32'(seg_a),  32'h00);
    check("rst.a.dig",  32'(dig_a),  32'h0);
    check("rst.a.tick", 32'(tick_a), 32'h0);
    check("rst.b.seg",  32'(seg_b),  32'hFF);
    check("rst.b.dig",  32'(dig_b),  32'hF);

    step();
    step();
    sin   = {8'h4F, 8'h5B, 8'h06, 8'h3F};
    Reset = 1'b0;
    repeat (3) step();

    // First frame: tick on the enabling edge, two blank cycles, then digit 0.
    Enable = 1'b1;
    step();
    check("start.a.tick", 32'(tick_a), 32'h1);
    check("start.a.dig",  32'(dig_a),  32'h0);
    step();
    step();
    check("d0.a.dig", 32'(dig_a), 32'h1);
    check("d0.a.seg", 32'(seg_a), 32'h3F);
    check("d0.b.dig", 32'(dig_b), 32'hE);
    check("d0.b.seg", 32'(seg_b), 32'hC0);
    wait_t(0, 10, "d1");
    check("d1.a.dig", 32'(dig_a), 32'h2);
    check("d1.a.seg", 32'(seg_a), 32'h06);

    // Pattern change during the digit-2 slot shows from the next frame.
    wait_t(0, 18, "chg");
    sin[0] = 8'h7F;
    wait_t(0, 31, "end1");
    check("end1.a.tick", 32'(tick_a), 32'h0);
    step();
    check("f2.a.tick", 32'(tick_a), 32'h1);
    wait_t(0, 2, "f2d0");
    check("f2.a.seg", 32'(seg_a), 32'h7F);

    // Enable drop in cycle 4 of the digit-1 slot, then re-enable.
    wait_t(0, 11, "drop");
    Enable = 1'b0;
    step();
    check("drop.a.dig", 32'(dig_a), 32'h0);
    repeat (3) step();
    Enable = 1'b1;
    step();
    check("reen.a.tick", 32'(tick_a), 32'h1);
    step();
    check("reen.a.blank", 32'(dig_a), 32'h0);
    step();
    check("reen.a.dig", 32'(dig_a), 32'h1);

    // Asynchronous reset between edges while digit 0 is driven.
    wait_t(0, 5, "arst");
    #3 Reset = 1'b1;
    #1;
    model_reset();
    compare_all("arst");
    check("arst.a.dig", 32'(dig_a), 32'h0);
    check("arst.b.seg", 32'(seg_b), 32'hFF);
    step();
    step();
    Reset = 1'b0;
    step();

    // Enable falling exactly on the frame wrap edge: no tick, no snapshot.
    wait_t(0, 31, "wrap");
    Enable = 1'b0;
    step();
    check("wrap.a.tick", 32'(tick_a), 32'h0);
    check("wrap.a.dig",  32'(dig_a),  32'h0);
    sin = {8'h66, 8'h6D, 8'h7D, 8'h07};
    repeat (2) step();
    Enable = 1'b1;

    // Randomized patterns and enable gaps.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) sin[$urandom_range(0, 3)] = 8'($urandom);
      if (Enable) begin
        if ($urandom_range(0, 149) == 0) Enable = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        Enable = 1'b1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
